bitwise_alu_cmd_sequencer: RTL and testbench
============================================

// Module: bitwise_alu_cmd_sequencer
// PURPOSE
//   Buffers bitwise-ALU commands {op_code, x, y} from a valid/ready producer in a FIFO.
//   Issues one command per cycle to the combinational bitwise_operators unit.
//   Registers each result and returns it on a valid/ready result channel.
//   Sits directly upstream of bitwise_operators (drives x/y/op_code) and captures its result.
// PARAMETERS
//   DW     8   operand/result width in bits; must match the bitwise_operators data ports
//   DEPTH  4   command FIFO entries; power of 2, >= 2
// PORTS
//   clk          in   1                 rising-edge clock, single clock domain
//   rst_n        in   1                 asynchronous active-low reset
//   cmd_valid    in   1                 command present
//   cmd_ready    out  1                 FIFO can accept a command
//   cmd_op       in   3                 op_code: 000 AND,001 NAND,010 OR,011 NOR,100 XOR,101 XNOR
//   cmd_x        in   DW                operand x
//   cmd_y        in   DW                operand y
//   cmd_chain    in   1                 use previous result as x (only with macro, see CONFIGURATION)
//   res_valid    out  1                 result register holds a result
//   res_ready    in   1                 consumer accepts result
//   res_data     out  DW                ALU result
//   res_op       out  3                 op_code that produced res_data
//   res_err      out  1                 op_code was 110/111 (illegal)
//   fifo_count   out  $clog2(DEPTH)+1   current FIFO occupancy
// BEHAVIOUR
//   - Reset (async assert, sync release): FIFO empty, fifo_count=0, cmd_ready=1, res_valid=0,
//     res_data=0, res_op=0, res_err=0. Reset mid-operation discards all buffered and held commands.
//   - Push: on the edge where cmd_valid && cmd_ready. cmd_ready = (fifo_count != DEPTH).
//     No same-cycle bypass when full: a pop does not free a slot for the same edge.
//   - Issue condition: fire = !empty && (!res_valid || res_ready).
//     The FIFO head drives the ALU combinationally. On fire: pop the head;
//     res_data <= ALU result; res_op <= head op; res_err <= (head op >= 3'b110).
//     Result register holds its value when not firing.
//   - Illegal op (110/111): res_data=0, res_err=1, still delivered in order.
//   - res_valid: set on fire. Cleared on res_valid && res_ready && !fire.
//     Held while res_ready=0, with res_data/res_op/res_err stable.
//   - Latency: command pushed at edge E into an empty FIFO with res_ready=1 gives res_valid=1
//     in the cycle after edge E+1. Sustained throughput is 1 result/cycle.
//   - Simultaneous push+pop: occupancy unchanged; pointers wrap modulo DEPTH.
//   - Ordering: strict FIFO order; no reordering or dropping.
//   - Push while empty AND fire in the same cycle: the new command is not issued that cycle.
// CONFIGURATION
//   Macro ALU_SEQ_CHAIN_EN.
//   - Defined: cmd_chain is stored with each entry. On fire of a chained entry, ALU x = last_res
//     instead of the stored x. last_res is an internal DW register, reset 0, updated on every fire.
//     Enables reductions like ((a&b)|c)^d.
//   - Undefined: cmd_chain is ignored and not stored; no last_res register; ALU x = stored x.
// STRUCTURE
//   - Package bitwise_alu_pkg: typedef enum logic [2:0] alu_op_e {OP_AND..OP_XNOR};
//     localparam ALU_OP_LAST = 3'b101; typedef struct packed alu_cmd_t {op, x, y[, chain]}.
//   - Sub-module alu_cmd_fifo: DEPTH x alu_cmd_t, push/pop/count, first-word-fall-through head.
//   - Instantiates bitwise_operators for the datapath; the sequencer adds no logic ops of its own.
// TESTING
//   1 Reset: assert rst_n=0 mid-stream with 3 entries queued -> next cycle fifo_count=0,
//     res_valid=0, cmd_ready=1.
//   2 Single op: push {op=000,x=8'hF0,y=8'h3C}, res_ready=1 -> 2 cycles later res_valid=1,
//     res_data=8'h30, res_op=000, res_err=0.
//   3 All ops, back-to-back, x=8'hAA y=8'h0F -> results in order:
//     0A,F5,AF,50,A5,5A; one result per cycle.
//   4 Backpressure: res_ready=0, push 5 cmds, DEPTH=4 -> 1 result held stable, FIFO full,
//     cmd_ready=0; release res_ready -> all 5 delivered in order, none lost.
//   5 Illegal op 3'b111, x=y=8'hFF -> res_data=0, res_err=1, res_op=111.
//   6 (ALU_SEQ_CHAIN_EN) push {000,FF,0F}, then {chain=1,010,--,30}, then {chain=1,100,--,FF}
//     -> results 0F, 3F, C0.

Source files
------------

// File: rtl/bitwise_alu_pkg.sv
// Shared types for the bitwise ALU command sequencer.
// Optional macro ALU_SEQ_CHAIN_EN adds a chain bit to each stored command.
package bitwise_alu_pkg;

    localparam int unsigned ALU_DW = 8;

    typedef enum logic [2:0] {
        OP_AND  = 3'b000,
        OP_NAND = 3'b001,
        OP_OR   = 3'b010,
        OP_NOR  = 3'b011,
        OP_XOR  = 3'b100,
        OP_XNOR = 3'b101
    } alu_op_e;

    localparam logic [2:0] ALU_OP_LAST = 3'b101;

    typedef struct packed {
        logic [2:0]        op;
        logic [ALU_DW-1:0] x;
        logic [ALU_DW-1:0] y;
`ifdef ALU_SEQ_CHAIN_EN
        logic              chain;
`endif
    } alu_cmd_t;

    function automatic logic op_illegal(input logic [2:0] op);
        return op > ALU_OP_LAST;
    endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// First-word-fall-through command FIFO; full blocks push even when popping that cycle.
module alu_cmd_fifo
    import bitwise_alu_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned AW = $clog2(DEPTH)
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     push,
    input  alu_cmd_t wdata,
    input  logic     pop,
    output alu_cmd_t rdata,
    output logic     full,
    output logic     empty,
    output logic [AW:0] count
);

    localparam logic [AW:0]   CNT_ONE = 1;
    localparam logic [AW:0]   CNT_MAX = DEPTH[AW:0];
    localparam logic [AW-1:0] PTR_ONE = 1;

    alu_cmd_t      mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign full    = (count_q == CNT_MAX);
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem_q[rd_ptr_q];
    assign count   = count_q;

    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + CNT_ONE;
        end else if (do_pop && !do_push) begin
            count_d = count_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            // Power-of-two depth lets the pointers wrap naturally.
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/bitwise_operators.sv
// Combinational bitwise ALU; op codes 110/111 are illegal and yield zero.
module bitwise_operators
    import bitwise_alu_pkg::*;
#(
    parameter int unsigned DW = 8
) (
    input  logic [2:0]    op_code,
    input  logic [DW-1:0] x,
    input  logic [DW-1:0] y,
    output logic [DW-1:0] result
);

    always_comb begin
        result = '0;
        case (alu_op_e'(op_code))
            OP_AND:  result = x & y;
            OP_NAND: result = ~(x & y);
            OP_OR:   result = x | y;
            OP_NOR:  result = ~(x | y);
            OP_XOR:  result = x ^ y;
            OP_XNOR: result = ~(x ^ y);
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/bitwise_alu_cmd_sequencer.sv
// Queues ALU commands, issues one per cycle to bitwise_operators, registers the result.
// Macro ALU_SEQ_CHAIN_EN: chained commands take x from the previous result.
module bitwise_alu_cmd_sequencer
    import bitwise_alu_pkg::*;
#(
    parameter int unsigned DW    = ALU_DW,  // must equal ALU_DW (command struct width)
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [2:0]               cmd_op,
    input  logic [DW-1:0]            cmd_x,
    input  logic [DW-1:0]            cmd_y,
    input  logic                     cmd_chain,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [DW-1:0]            res_data,
    output logic [2:0]               res_op,
    output logic                     res_err,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    alu_cmd_t      wr_cmd, head;
    logic          fifo_full, fifo_empty, fire;
    logic [DW-1:0] alu_x, alu_res;

    logic          res_valid_q;
    logic [DW-1:0] res_data_q;
    logic [2:0]    res_op_q;
    logic          res_err_q;

    always_comb begin
        wr_cmd    = '0;
        wr_cmd.op = cmd_op;
        wr_cmd.x  = cmd_x;
        wr_cmd.y  = cmd_y;
`ifdef ALU_SEQ_CHAIN_EN
        wr_cmd.chain = cmd_chain;
`endif
    end

`ifndef ALU_SEQ_CHAIN_EN
    logic unused_chain;
    assign unused_chain = cmd_chain;
`endif

    alu_cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (cmd_valid),
        .wdata (wr_cmd),
        .pop   (fire),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign cmd_ready = !fifo_full;
    assign fire      = !fifo_empty && (!res_valid_q || res_ready);

`ifdef ALU_SEQ_CHAIN_EN
    logic [DW-1:0] last_res_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_res_q <= '0;
        end else if (fire) begin
            last_res_q <= alu_res;
        end
    end

    assign alu_x = head.chain ? last_res_q : head.x;
`else
    assign alu_x = head.x;
`endif

    bitwise_operators #(
        .DW (DW)
    ) u_ops (
        .op_code (head.op),
        .x       (alu_x),
        .y       (head.y),
        .result  (alu_res)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_op_q    <= '0;
            res_err_q   <= 1'b0;
        end else if (fire) begin
            res_valid_q <= 1'b1;
            res_data_q  <= alu_res;
            res_op_q    <= head.op;
            res_err_q   <= op_illegal(head.op);
        end else if (res_ready) begin
            res_valid_q <= 1'b0;
        end
    end

    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_op    = res_op_q;
    assign res_err   = res_err_q;

endmodule

// File: tb/tb_bitwise_alu_cmd_sequencer.sv
// Directed self-checking bench for bitwise_alu_cmd_sequencer (DW=8, DEPTH=4).
module tb_bitwise_alu_cmd_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid, cmd_ready, cmd_chain;
    logic [2:0] cmd_op;
    logic [7:0] cmd_x, cmd_y;
    logic       res_valid, res_ready, res_err;
    logic [7:0] res_data;
    logic [2:0] res_op;
    logic [2:0] fifo_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bitwise_alu_cmd_sequencer #(
        .DW    (8),
        .DEPTH (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_x      (cmd_x),
        .cmd_y      (cmd_y),
        .cmd_chain  (cmd_chain),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_op     (res_op),
        .res_err    (res_err),
        .fifo_count (fifo_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Holds cmd_valid until the command is accepted, bounded to 20 cycles.
    task automatic push_cmd(input logic [2:0] op, input logic [7:0] x, input logic [7:0] y,
                            input logic ch);
        bit done;
        done      = 1'b0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_x     = x;
        cmd_y     = y;
        cmd_chain = ch;
        for (int i = 0; i < 20 && !done; i++) begin
            done = cmd_ready;
            tick();
        end
        cmd_valid = 1'b0;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL push_accept: got not accepted, expected accepted");
        end
    endtask

    task automatic drain();
        res_ready = 1'b1;
        repeat (8) tick();
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = '0;
        cmd_x     = '0;
        cmd_y     = '0;
        cmd_chain = 1'b0;
        res_ready = 1'b0;
        repeat (2) tick();
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", fifo_count); end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %b expected 1", cmd_ready); end
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid: got %b expected 0", res_valid); end
        checks++; if (res_data !== 8'h00) begin errors++; $display("FAIL reset_res_data: got %h expected 00", res_data); end
        checks++; if (res_op !== 3'd0 || res_err !== 1'b0) begin errors++; $display("FAIL reset_res_op_err: got %b/%b expected 000/0", res_op, res_err); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset_midstream();
        res_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_cmd(3'b010, 8'(i), 8'h01, 1'b0);
        checks++; if (fifo_count !== 3'd3) begin errors++; $display("FAIL mid_count_before: got %0d expected 3", fifo_count); end
        checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL mid_valid_before: got %b expected 1", res_valid); end
        rst_n = 1'b0;
        #1;
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL mid_reset_count: got %0d expected 0", fifo_count); end
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_valid: got %b expected 0", res_valid); end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL mid_reset_ready: got %b expected 1", cmd_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checks++; if (res_valid !== 1'b0 || fifo_count !== 3'd0) begin errors++; $display("FAIL mid_after_release: got valid=%b count=%0d expected 0/0", res_valid, fifo_count); end
    endtask

    task automatic test_single();
        res_ready = 1'b1;
        push_cmd(3'b000, 8'hF0, 8'h3C, 1'b0);
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL single_early: got valid=%b expected 0", res_valid); end
        tick();
        checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b expected 1", res_valid); end
        checks++; if (res_data !== 8'h30) begin errors++; $display("FAIL single_data: got %h expected 30", res_data); end
        checks++; if (res_op !== 3'b000 || res_err !== 1'b0) begin errors++; $display("FAIL single_op_err: got %b/%b expected 000/0", res_op, res_err); end
        tick();
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL single_consumed: got %b expected 0", res_valid); end
    endtask

    task automatic test_all_ops();
        logic [7:0] exp_data [6];
        exp_data = '{8'h0A, 8'hF5, 8'hAF, 8'h50, 8'hA5, 8'h5A};
        res_ready = 1'b1;
        cmd_x     = 8'hAA;
        cmd_y     = 8'h0F;
        cmd_chain = 1'b0;
        for (int i = 0; i <= 6; i++) begin
            cmd_valid = (i < 6);
            cmd_op    = 3'(i);
            tick();
            if (i >= 1) begin
                checks++;
                if (res_valid !== 1'b1 || res_data !== exp_data[i-1] || res_op !== 3'(i - 1)) begin
                    errors++;
                    $display("FAIL all_ops[%0d]: got valid=%b data=%h op=%b expected 1/%h/%b",
                             i - 1, res_valid, res_data, res_op, exp_data[i-1], 3'(i - 1));
                end
            end
        end
        cmd_valid = 1'b0;
        tick();
    endtask

    task automatic test_backpressure();
        int got;
        res_ready = 1'b0;
        for (int i = 0; i < 5; i++) push_cmd(3'b100, 8'h10 + 8'(i), 8'hFF, 1'b0);
        checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL bp_full_count: got %0d expected 4", fifo_count); end
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL bp_cmd_ready: got %b expected 0", cmd_ready); end
        repeat (3) tick();
        checks++; if (res_valid !== 1'b1 || res_data !== 8'hEF || res_op !== 3'b100) begin errors++; $display("FAIL bp_held: got valid=%b data=%h op=%b expected 1/ef/100", res_valid, res_data, res_op); end
        checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL bp_count_stable: got %0d expected 4", fifo_count); end
        res_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 20 && got < 5; c++) begin
            if (res_valid) begin
                checks++;
                if (res_data !== 8'hEF - 8'(got)) begin
                    errors++;
                    $display("FAIL bp_order[%0d]: got %h expected %h", got, res_data, 8'hEF - 8'(got));
                end
                got++;
            end
            tick();
        end
        checks++; if (got !== 5) begin errors++; $display("FAIL bp_delivered: got %0d expected 5", got); end
        checks++; if (res_valid !== 1'b0 || fifo_count !== 3'd0) begin errors++; $display("FAIL bp_drained: got valid=%b count=%0d expected 0/0", res_valid, fifo_count); end
    endtask

    task automatic test_illegal();
        res_ready = 1'b1;
        push_cmd(3'b111, 8'hFF, 8'hFF, 1'b0);
        tick();
        checks++; if (res_valid !== 1'b1 || res_data !== 8'h00) begin errors++; $display("FAIL illegal_data: got valid=%b data=%h expected 1/00", res_valid, res_data); end
        checks++; if (res_err !== 1'b1 || res_op !== 3'b111) begin errors++; $display("FAIL illegal_err_op: got %b/%b expected 1/111", res_err, res_op); end
        push_cmd(3'b110, 8'h0F, 8'hF0, 1'b0);
        tick();
        checks++; if (res_err !== 1'b1 || res_op !== 3'b110 || res_data !== 8'h00) begin errors++; $display("FAIL illegal_110: got err=%b op=%b data=%h expected 1/110/00", res_err, res_op, res_data); end
        push_cmd(3'b101, 8'h0F, 8'h0F, 1'b0);
        tick();
        checks++; if (res_err !== 1'b0 || res_data !== 8'hFF) begin errors++; $display("FAIL legal_after_illegal: got err=%b data=%h expected 0/ff", res_err, res_data); end
        drain();
    endtask

`ifdef ALU_SEQ_CHAIN_EN
    task automatic test_chain();
        logic [2:0] ops  [3];
        logic [7:0] xs   [3];
        logic [7:0] ys   [3];
        logic       chs  [3];
        logic [7:0] exps [3];
        ops  = '{3'b000, 3'b010, 3'b100};
        xs   = '{8'hFF, 8'h00, 8'h00};
        ys   = '{8'h0F, 8'h30, 8'hFF};
        chs  = '{1'b0, 1'b1, 1'b1};
        exps = '{8'h0F, 8'h3F, 8'hC0};
        res_ready = 1'b1;
        for (int i = 0; i <= 3; i++) begin
            cmd_valid = (i < 3);
            if (i < 3) begin
                cmd_op    = ops[i];
                cmd_x     = xs[i];
                cmd_y     = ys[i];
                cmd_chain = chs[i];
            end
            tick();
            if (i >= 1) begin
                checks++;
                if (res_valid !== 1'b1 || res_data !== exps[i-1]) begin
                    errors++;
                    $display("FAIL chain[%0d]: got valid=%b data=%h expected 1/%h",
                             i - 1, res_valid, res_data, exps[i-1]);
                end
            end
        end
        cmd_valid = 1'b0;
        cmd_chain = 1'b0;
        drain();
    endtask
`endif

    initial begin
        test_reset();
        test_reset_midstream();
        test_single();
        test_all_ops();
        test_backpressure();
        test_illegal();
`ifdef ALU_SEQ_CHAIN_EN
        test_chain();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
